// File: rtl/cell_comm_rx_checker.sv
// cell_comm_rx_checker
// Receive-side checker for the cell-controller fast-orbit link. Validates
// 4-word BPM packets (header magic, length, CRC status from the Aurora core)
// and forwards only intact packets as a single-cycle record. Malformed
// packets are dropped and counted.
module cell_comm_rx_checker #(
  parameter int          FOFB_IDX_WIDTH = 9,
  parameter logic [15:0] MAGIC          = 16'hA5BE,
  parameter int          CRC_TIMEOUT    = 7,
  parameter int          COUNT_WIDTH    = 16
) (
  input  logic                      rxClk,
  input  logic                      rxReset_n,
  input  logic                      rxValid,
  input  logic                      rxLast,
  input  logic [31:0]               rxData,
  input  logic                      rxCRCvalid,
  input  logic                      rxCRCpass,
  input  logic                      clearCounters,
  output logic                      outValid,
  output logic [FOFB_IDX_WIDTH-1:0] outIndex,
  output logic                      outClipping,
  output logic [31:0]               outX,
  output logic [31:0]               outY,
  output logic [31:0]               outS,
  output logic                      errHeader,
  output logic                      errLength,
  output logic                      errCRC,
  output logic [COUNT_WIDTH-1:0]    goodCount,
  output logic [COUNT_WIDTH-1:0]    headerErrCount,
  output logic [COUNT_WIDTH-1:0]    lengthErrCount,
  output logic [COUNT_WIDTH-1:0]    crcErrCount
);

  localparam int TIMER_WIDTH = $clog2(CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BODY     = 2'd1,
    CRC_WAIT = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t                    r_state;
  logic [1:0]                r_wordCnt;
  logic [TIMER_WIDTH-1:0]    r_timer;
  logic [FOFB_IDX_WIDTH-1:0] r_shIndex;
  logic                      r_shClip;
  logic [31:0]               r_shX;
  logic [31:0]               r_shY;
  logic [31:0]               r_shS;

  state_t                    w_nextState;
  logic [1:0]                w_nextWordCnt;
  logic [TIMER_WIDTH-1:0]    w_nextTimer;
  logic                      w_magicOk;
  logic                      w_headerBeat;
  logic                      w_hdrErr;
  logic                      w_lenErr;
  logic                      w_crcErr;
  logic                      w_commit;
  logic                      w_commitFromBeat;
  logic                      w_latchHdr;
  logic                      w_latchX;
  logic                      w_latchY;
  logic                      w_latchS;

  assign w_magicOk = (rxData[31:16] == MAGIC);

  // Saturating increment shared by the four statistics counters
  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] v,
                                                  input logic inc);
    if (inc && (v != {COUNT_WIDTH{1'b1}})) begin
      return v + COUNT_WIDTH'(1);
    end
    return v;
  endfunction

  // State register plus word counter and CRC-status timeout counter
  always_ff @(posedge rxClk) begin
    if (!rxReset_n) begin
      r_state   <= IDLE;
      r_wordCnt <= 2'd0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_wordCnt <= w_nextWordCnt;
      r_timer   <= w_nextTimer;
    end
  end

  // Next-state decode; a beat seen while waiting for CRC abandons that packet and is re-used as a header
  always_comb begin
    w_nextState      = r_state;
    w_nextWordCnt    = r_wordCnt;
    w_nextTimer      = r_timer;
    w_headerBeat     = 1'b0;
    w_hdrErr         = 1'b0;
    w_lenErr         = 1'b0;
    w_crcErr         = 1'b0;
    w_commit         = 1'b0;
    w_commitFromBeat = 1'b0;
    w_latchHdr       = 1'b0;
    w_latchX         = 1'b0;
    w_latchY         = 1'b0;
    w_latchS         = 1'b0;

    case (r_state)
      IDLE: begin
        if (rxValid) begin
          w_headerBeat = 1'b1;
        end
      end
      BODY: begin
        if (rxValid) begin
          case (r_wordCnt)
            2'd0: begin
              w_latchX = 1'b1;
              if (rxLast) begin
                w_lenErr    = 1'b1;
                w_nextState = IDLE;
              end else begin
                w_nextWordCnt = 2'd1;
              end
            end
            2'd1: begin
              w_latchY = 1'b1;
              if (rxLast) begin
                w_lenErr    = 1'b1;
                w_nextState = IDLE;
              end else begin
                w_nextWordCnt = 2'd2;
              end
            end
            default: begin
              w_latchS = 1'b1;
              if (!rxLast) begin
                w_lenErr    = 1'b1;
                w_nextState = DROP;
              end else if (rxCRCvalid) begin
                w_commit         = rxCRCpass;
                w_commitFromBeat = rxCRCpass;
                w_crcErr         = !rxCRCpass;
                w_nextState      = IDLE;
              end else begin
                w_nextTimer = TIMER_WIDTH'(CRC_TIMEOUT);
                w_nextState = CRC_WAIT;
              end
            end
          endcase
        end
      end
      CRC_WAIT: begin
        if (rxValid) begin
          w_crcErr     = 1'b1;
          w_headerBeat = 1'b1;
        end else if (rxCRCvalid) begin
          w_commit    = rxCRCpass;
          w_crcErr    = !rxCRCpass;
          w_nextState = IDLE;
        end else if (r_timer <= TIMER_WIDTH'(1)) begin
          w_crcErr    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextTimer = r_timer - TIMER_WIDTH'(1);
        end
      end
      DROP: begin
        if (rxValid && rxLast) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    // A header carrying tlast has no body at all, so it is a short packet
    if (w_headerBeat) begin
      if (!w_magicOk) begin
        w_hdrErr    = 1'b1;
        w_nextState = rxLast ? IDLE : DROP;
      end else begin
        w_latchHdr    = 1'b1;
        w_nextWordCnt = 2'd0;
        if (rxLast) begin
          w_lenErr    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextState = BODY;
        end
      end
    end
  end

  // Shadow registers collect the packet being received until CRC decides its fate
  always_ff @(posedge rxClk) begin
    if (!rxReset_n) begin
      r_shIndex <= '0;
      r_shClip  <= 1'b0;
      r_shX     <= '0;
      r_shY     <= '0;
      r_shS     <= '0;
    end else begin
      if (w_latchHdr) begin
        r_shIndex <= rxData[FOFB_IDX_WIDTH-1:0];
        r_shClip  <= rxData[15];
      end
      if (w_latchX) begin
        r_shX <= rxData;
      end
      if (w_latchY) begin
        r_shY <= rxData;
      end
      if (w_latchS) begin
        r_shS <= rxData;
      end
    end
  end

  // Registered outputs; data only moves on a commit, S bypasses the shadow when CRC arrives with tlast
  always_ff @(posedge rxClk) begin
    if (!rxReset_n) begin
      outValid    <= 1'b0;
      errHeader   <= 1'b0;
      errLength   <= 1'b0;
      errCRC      <= 1'b0;
      outIndex    <= '0;
      outClipping <= 1'b0;
      outX        <= '0;
      outY        <= '0;
      outS        <= '0;
    end else begin
      outValid  <= w_commit;
      errHeader <= w_hdrErr;
      errLength <= w_lenErr;
      errCRC    <= w_crcErr;
      if (w_commit) begin
        outIndex    <= r_shIndex;
        outClipping <= r_shClip;
        outX        <= r_shX;
        outY        <= r_shY;
        outS        <= w_commitFromBeat ? rxData : r_shS;
      end
    end
  end

  // Statistics counters update on the same edge as their strobe; clear beats a coincident increment
  always_ff @(posedge rxClk) begin
    if (!rxReset_n || clearCounters) begin
      goodCount      <= '0;
      headerErrCount <= '0;
      lengthErrCount <= '0;
      crcErrCount    <= '0;
    end else begin
      goodCount      <= bump(goodCount, w_commit);
      headerErrCount <= bump(headerErrCount, w_hdrErr);
      lengthErrCount <= bump(lengthErrCount, w_lenErr);
      crcErrCount    <= bump(crcErrCount, w_crcErr);
    end
  end

endmodule
